// File: rtl/rtmc_spi_ctrl.sv
// rtmc_spi_ctrl: register read/write requests carried over a mode-0 SPI frame.
// Frame (MSB first): R/W bit (1 = read), addr, then data (wdat on writes, zeros on reads).
// Optional feature: define RTMC_SPI_CS_GAP_EN to hold cs high for 2*CLK_DIV extra cycles
// (state GAP) after every frame before a new request is accepted.
module rtmc_spi_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] rdat,
  output logic              ack,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned N_BITS = 1 + ADDR_W + DATA_W;
  localparam int unsigned HALF_W = $clog2(2 * N_BITS);
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3
`ifdef RTMC_SPI_CS_GAP_EN
    ,S_GAP  = 3'd4
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
  logic [HALF_W-1:0]   r_half,  w_half_nxt;
  logic [N_BITS-1:0]   r_sh,    w_sh_nxt;
  logic [DATA_W-1:0]   r_rx,    w_rx_nxt;
  logic [DATA_W-1:0]   r_rdat,  w_rdat_nxt;
  logic                r_read,  w_read_nxt;
  logic                r_sclk,  w_sclk_nxt;
  logic                r_cs,    w_cs_nxt;
  logic                r_mosi,  w_mosi_nxt;
  logic                r_ack,   w_ack_nxt;
  logic                r_busy,  w_busy_nxt;
  logic                w_tick;
  logic                w_is_rd;
  logic                w_last_half;

  // Half-period boundary, request type (write wins) and final-half detect
  assign w_tick      = (r_cnt == '0);
  assign w_is_rd     = rd & ~wr;
  assign w_last_half = (r_half == HALF_W'(2 * N_BITS - 1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_half_nxt  = r_half;
    w_sh_nxt    = r_sh;
    w_rx_nxt    = r_rx;
    w_rdat_nxt  = r_rdat;
    w_read_nxt  = r_read;
    w_sclk_nxt  = r_sclk;
    w_cs_nxt    = r_cs;
    w_mosi_nxt  = r_mosi;
    w_ack_nxt   = 1'b0;
    w_busy_nxt  = r_busy;

    case (r_state)
      S_IDLE: begin
        if (wr || rd) begin
          w_state_nxt = S_SETUP;
          w_read_nxt  = w_is_rd;
          w_sh_nxt    = {w_is_rd, addr, (w_is_rd ? {DATA_W{1'b0}} : wdat)};
          w_mosi_nxt  = w_is_rd;
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_cnt_nxt   = CNT_W'(CLK_DIV - 1);
          w_half_nxt  = '0;
          w_rx_nxt    = '0;
        end
      end

      S_SETUP: begin
        if (w_tick) begin
          w_state_nxt = S_SHIFT;
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = {r_rx[DATA_W-2:0], miso};
          w_cnt_nxt   = CNT_W'(CLK_DIV - 1);
          w_half_nxt  = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (w_tick) begin
          w_cnt_nxt = CNT_W'(CLK_DIV - 1);
          if (r_sclk) begin
            // falling edge: advance mosi to the next frame bit
            w_sclk_nxt = 1'b0;
            w_sh_nxt   = {r_sh[N_BITS-2:0], 1'b0};
            w_mosi_nxt = r_sh[N_BITS-2];
            w_half_nxt = r_half + HALF_W'(1);
          end else if (w_last_half) begin
            w_state_nxt = S_HOLD;
          end else begin
            // rising edge: capture miso
            w_sclk_nxt = 1'b1;
            w_rx_nxt   = {r_rx[DATA_W-2:0], miso};
            w_half_nxt = r_half + HALF_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (w_tick) begin
          w_ack_nxt  = 1'b1;
          w_cs_nxt   = 1'b1;
          w_mosi_nxt = 1'b0;
          w_sh_nxt   = '0;
          if (r_read) begin
            w_rdat_nxt = r_rx;
          end
`ifdef RTMC_SPI_CS_GAP_EN
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(2 * CLK_DIV - 1);
`else
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

`ifdef RTMC_SPI_CS_GAP_EN
      S_GAP: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
        w_cs_nxt    = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_sh    <= '0;
      r_rx    <= '0;
      r_rdat  <= '0;
      r_read  <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_sh    <= w_sh_nxt;
      r_rx    <= w_rx_nxt;
      r_rdat  <= w_rdat_nxt;
      r_read  <= w_read_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs    <= w_cs_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign rdat = r_rdat;
  assign ack  = r_ack;
  assign busy = r_busy;
  assign sclk = r_sclk;
  assign cs   = r_cs;
  assign mosi = r_mosi;

endmodule

// File: tb/tb_rtmc_spi_ctrl.sv
// tb_rtmc_spi_ctrl: directed bench for rtmc_spi_ctrl with CLK_DIV=1 and CLK_DIV=2 instances.
// A mode-0 peripheral model drives miso for whichever instance is selected.
module tb_rtmc_spi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic [15:0] wdat;
  logic        wr, rd;
  logic        miso = 1'b0;
  logic        sel_d1;

  logic [15:0] rdat_d1, rdat_d2;
  logic        ack_d1, ack_d2, busy_d1, busy_d2, sclk_d1, sclk_d2;
  logic        cs_d1, cs_d2, mosi_d1, mosi_d2;

  logic        wr_d1, rd_d1, wr_d2, rd_d2;
  logic [15:0] m_rdat;
  logic        m_ack, m_busy, m_sclk, m_cs, m_mosi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign wr_d1 = wr & sel_d1;
  assign rd_d1 = rd & sel_d1;
  assign wr_d2 = wr & ~sel_d1;
  assign rd_d2 = rd & ~sel_d1;

  assign m_rdat = sel_d1 ? rdat_d1 : rdat_d2;
  assign m_ack  = sel_d1 ? ack_d1  : ack_d2;
  assign m_busy = sel_d1 ? busy_d1 : busy_d2;
  assign m_sclk = sel_d1 ? sclk_d1 : sclk_d2;
  assign m_cs   = sel_d1 ? cs_d1   : cs_d2;
  assign m_mosi = sel_d1 ? mosi_d1 : mosi_d2;

  rtmc_spi_ctrl #(.ADDR_W(8), .DATA_W(16), .CLK_DIV(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdat(wdat), .wr(wr_d1), .rd(rd_d1),
    .rdat(rdat_d1), .ack(ack_d1), .busy(busy_d1), .sclk(sclk_d1), .cs(cs_d1),
    .mosi(mosi_d1), .miso(miso)
  );

  rtmc_spi_ctrl #(.ADDR_W(8), .DATA_W(16), .CLK_DIV(2)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdat(wdat), .wr(wr_d2), .rd(rd_d2),
    .rdat(rdat_d2), .ack(ack_d2), .busy(busy_d2), .sclk(sclk_d2), .cs(cs_d2),
    .mosi(mosi_d2), .miso(miso)
  );

  // Mode-0 peripheral: first bit on cs fall, next bit after each sclk fall
  logic [24:0] s_frame = '0;
  int          s_idx   = 0;
  logic        p_cs    = 1'b1;
  logic        p_sclk  = 1'b0;

  always @(negedge clk) begin
    if (p_cs && !m_cs) begin
      s_idx = 24;
      miso  = s_frame[24];
    end else if (!m_cs && p_sclk && !m_sclk) begin
      if (s_idx > 0) s_idx = s_idx - 1;
      miso = s_frame[s_idx];
    end else if (m_cs) begin
      miso = 1'b0;
    end
    p_cs   = m_cs;
    p_sclk = m_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and follow the frame to its ack
  task automatic run_frame(input string tag, input logic w, input logic r,
                           input logic [7:0] a, input logic [15:0] d, input logic [15:0] mword,
                           input int abort_rise, input int extra_j, input logic [15:0] exp_rdat);
    int cdiv, j, jack, rises, cslow, acks, mosi_bad;
    logic [24:0] exp_frame, cap;
    logic psclk;
    bit done;
    cdiv      = sel_d1 ? 1 : 2;
    exp_frame = {r & ~w, a, (w ? d : 16'h0000)};
    s_frame   = {9'h000, mword};
    wr = w; rd = r; addr = a; wdat = d;
    j = 0; jack = 0; rises = 0; cslow = 0; acks = 0; mosi_bad = 0;
    cap = '0; psclk = 1'b0; done = 1'b0;
    while (!done && j < 400) begin
      @(negedge clk);
      j++;
      if (j == 1) begin wr = 1'b0; rd = 1'b0; end
      if (j == extra_j) begin wr = 1'b1; addr = 8'h77; wdat = 16'h1357; end
      if (extra_j > 0 && j == extra_j + 1) wr = 1'b0;
      if (j == 2) chk({tag, "_busy_mid"}, 32'(m_busy), 32'd1);
      if (m_sclk && !psclk) begin
        rises++;
        cap = {cap[23:0], m_mosi};
      end
      psclk = m_sclk;
      if (!m_cs) cslow++;
      if (m_cs && m_mosi) mosi_bad++;
      if (m_ack) begin acks++; jack = j; done = 1'b1; end
      if (abort_rise > 0 && rises == abort_rise) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_cs"},   32'(m_cs),   32'd1);
        chk({tag, "_rst_sclk"}, 32'(m_sclk), 32'd0);
        chk({tag, "_rst_busy"}, 32'(m_busy), 32'd0);
        chk({tag, "_rst_ack"},  32'(m_ack),  32'd0);
        chk({tag, "_rst_rdat"}, 32'(m_rdat), 32'd0);
        chk({tag, "_rst_noack"}, 32'(acks),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    chk({tag, "_ack_cycle"}, 32'(jack),     32'(cdiv * 52 + 1));
    chk({tag, "_rises"},     32'(rises),    32'd25);
    chk({tag, "_mosi"},      32'(cap),      32'(exp_frame));
    chk({tag, "_cs_low"},    32'(cslow),    32'(cdiv * 52));
    chk({tag, "_cs_ack"},    32'(m_cs),     32'd1);
    chk({tag, "_mosi_idle"}, 32'(mosi_bad), 32'd0);
    chk({tag, "_rdat"},      32'(m_rdat),   32'(exp_rdat));
`ifdef RTMC_SPI_CS_GAP_EN
    chk({tag, "_busy_ack"},  32'(m_busy),   32'd1);
    repeat (2 * cdiv) @(negedge clk);
`else
    chk({tag, "_busy_ack"},  32'(m_busy),   32'd0);
`endif
  endtask

  // Watch an idle stretch: no ack, cs stays high, mosi low
  task automatic idle_watch(input string tag, input int n);
    int acks, cslow, mosi_bad;
    acks = 0; cslow = 0; mosi_bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_ack) acks++;
      if (!m_cs) cslow++;
      if (m_mosi) mosi_bad++;
    end
    chk({tag, "_acks"},  32'(acks),     32'd0);
    chk({tag, "_cslow"}, 32'(cslow),    32'd0);
    chk({tag, "_mosi"},  32'(mosi_bad), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdat = '0; sel_d1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_d1",   32'(cs_d1),   32'd1);
    chk("rst_sclk_d1", 32'(sclk_d1), 32'd0);
    chk("rst_mosi_d1", 32'(mosi_d1), 32'd0);
    chk("rst_ack_d1",  32'(ack_d1),  32'd0);
    chk("rst_busy_d1", 32'(busy_d1), 32'd0);
    chk("rst_rdat_d1", 32'(rdat_d1), 32'd0);
    chk("rst_cs_d2",   32'(cs_d2),   32'd1);
    chk("rst_sclk_d2", 32'(sclk_d2), 32'd0);
    chk("rst_mosi_d2", 32'(mosi_d2), 32'd0);
    chk("rst_ack_d2",  32'(ack_d2),  32'd0);
    chk("rst_busy_d2", 32'(busy_d2), 32'd0);
    chk("rst_rdat_d2", 32'(rdat_d2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // CLK_DIV=1 write: 25-bit frame, ack at T0+53, rdat untouched
    run_frame("wr_div1", 1'b1, 1'b0, 8'h5A, 16'hBEEF, 16'hFFFF, 0, 0, 16'h0000);
    idle_watch("wr_div1_idle", 5);

    // CLK_DIV=2 read: ack at T0+105, rdat from the last 16 miso bits
    sel_d1 = 1'b0;
    @(negedge clk);
    run_frame("rd_div2", 1'b0, 1'b1, 8'h03, 16'hDEAD, 16'h1234, 0, 0, 16'h1234);
    @(negedge clk);

    // wr and rd together execute as a write
    run_frame("wrrd", 1'b1, 1'b1, 8'hC3, 16'hA55A, 16'hFFFF, 0, 0, 16'h1234);
    @(negedge clk);

    // Request at T0+10 while busy is dropped: one frame, one ack
    run_frame("discard", 1'b1, 1'b0, 8'h11, 16'h2222, 16'hFFFF, 0, 10, 16'h1234);
    idle_watch("discard_idle", 40);

    // Back-to-back: second request presented in the ack cycle
    run_frame("b2b_1", 1'b1, 1'b0, 8'h20, 16'h0F0F, 16'h0000, 0, 0, 16'h1234);
    run_frame("b2b_2", 1'b0, 1'b1, 8'h21, 16'h0000, 16'hCAFE, 0, 0, 16'hCAFE);
    @(negedge clk);

    // Reset at bit 10 of a read, then a clean read afterwards
    run_frame("abort", 1'b0, 1'b1, 8'h30, 16'h0000, 16'h5555, 10, 0, 16'h0000);
    idle_watch("abort_idle", 4);
    run_frame("post_rst", 1'b0, 1'b1, 8'h44, 16'h0000, 16'h9876, 0, 0, 16'h9876);
    idle_watch("end_idle", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
